// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : WIDTH-bit ALU with Start/Busy/Done handshake and iterative MUL/DIV
// Revision : 1.0
// ============================================================================

module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Err,
    output logic             Busy,
    output logic             Done
);
    localparam int             SHW       = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             divz_q, divz_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    // Single-cycle datapath
    logic [WIDTH:0]   w_add, w_sub;
    logic             w_bneg_msb;
    logic [SHW-1:0]   w_shamt;
    logic             w_is_multi;
    logic [WIDTH-1:0] w_sc_out;
    logic             w_sc_carry, w_sc_ovf, w_sc_err;

    assign w_add   = {1'b0, A} + {1'b0, B};
    assign w_sub   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    // MSB of ~B+1: flips B's MSB unless the low bits are all zero
    assign w_bneg_msb = (B[WIDTH-2:0] == '0) ? B[WIDTH-1] : ~B[WIDTH-1];
    assign w_shamt    = B[SHW-1:0];
    assign w_is_multi = (Op == OP_MUL) || (Op == OP_DIVU) || (Op == OP_REMU);

    always_comb begin
        w_sc_out   = '0;
        w_sc_carry = 1'b0;
        w_sc_ovf   = 1'b0;
        w_sc_err   = 1'b0;
        case (Op)
            OP_AND: w_sc_out = A & B;
            OP_OR:  w_sc_out = A | B;
            OP_ADD: begin
                w_sc_out   = w_add[WIDTH-1:0];
                w_sc_carry = w_add[WIDTH];
                w_sc_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_out   = w_sub[WIDTH-1:0];
                w_sc_carry = w_sub[WIDTH];
                w_sc_ovf   = (A[WIDTH-1] == w_bneg_msb) && (w_sub[WIDTH-1] != A[WIDTH-1]);
            end
            OP_XOR: w_sc_out = A ^ B;
            OP_NOR: w_sc_out = ~(A | B);
            OP_SLT: w_sc_out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL: w_sc_out = A << w_shamt;
            OP_SRL: w_sc_out = A >> w_shamt;
            OP_SRA: w_sc_out = $unsigned($signed(A) >>> w_shamt);
            OP_MUL, OP_DIVU, OP_REMU: w_sc_out = '0;
            default: w_sc_err = 1'b1;
        endcase
    end

    // Iteration datapath: acc = product / partial remainder,
    // x = shifted multiplicand / dividend-then-quotient, y = multiplier / divisor
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_div_sh, w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt, w_seq_res;

    assign w_mul_acc  = acc_q + (y_q[0] ? x_q : '0);
    assign w_div_sh   = {acc_q, x_q[WIDTH-1]};
    assign w_div_diff = w_div_sh - {1'b0, y_q};
    // A zero divisor always "fits": quotient becomes all-ones, remainder collects A
    assign w_div_ge   = divz_q || !w_div_diff[WIDTH];
    assign w_rem_nxt  = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
    assign w_quo_nxt  = {x_q[WIDTH-2:0], w_div_ge};
    assign w_seq_res  = (op_q == OP_MUL)  ? w_mul_acc :
                        (op_q == OP_DIVU) ? w_quo_nxt : w_rem_nxt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        divz_d  = divz_q;
        out_d   = out_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (Start) begin
                    if (w_is_multi) begin
                        op_d    = Op;
                        acc_d   = '0;
                        x_d     = A;
                        y_d     = B;
                        divz_d  = (B == '0);
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        out_d   = w_sc_out;
                        zero_d  = (w_sc_out == '0);
                        carry_d = w_sc_carry;
                        ovf_d   = w_sc_ovf;
                        err_d   = w_sc_err;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + SHW'(1);
                if (op_q == OP_MUL) begin
                    acc_d = w_mul_acc;
                    x_d   = x_q << 1;
                    y_d   = y_q >> 1;
                end else begin
                    acc_d = w_rem_nxt;
                    x_d   = w_quo_nxt;
                end
                if (cnt_q == LAST_ITER) begin
                    out_d   = w_seq_res;
                    zero_d  = (w_seq_res == '0);
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    err_d   = (op_q != OP_MUL) && divz_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            divz_q  <= 1'b0;
            out_q   <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            divz_q  <= divz_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign Out      = out_q;
    assign Zero     = zero_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;
    assign Err      = err_q;
    assign Busy     = (state_q == S_RUN);
    assign Done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_seq : scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8
// Revision : 1.0
// ============================================================================

module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic        s32_start = 1'b0;
    logic [31:0] s32_a = '0, s32_b = '0, s32_out;
    logic [3:0]  s32_op = '0;
    logic        s32_zero, s32_carry, s32_ovf, s32_err, s32_busy, s32_done;

    logic        s8_start = 1'b0;
    logic [7:0]  s8_a = '0, s8_b = '0, s8_out;
    logic [3:0]  s8_op = '0;
    logic        s8_zero, s8_carry, s8_ovf, s8_err, s8_busy, s8_done;

    alu_seq #(.WIDTH(32)) u_dut32 (
        .Clk(clk), .Reset(rst_n), .Start(s32_start), .A(s32_a), .B(s32_b), .Op(s32_op),
        .Out(s32_out), .Zero(s32_zero), .Carry(s32_carry), .Overflow(s32_ovf),
        .Err(s32_err), .Busy(s32_busy), .Done(s32_done)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .Clk(clk), .Reset(rst_n), .Start(s8_start), .A(s8_a), .B(s8_b), .Op(s8_op),
        .Out(s8_out), .Zero(s8_zero), .Carry(s8_carry), .Overflow(s8_ovf),
        .Err(s8_err), .Busy(s8_busy), .Done(s8_done)
    );

    typedef struct packed {
        logic [31:0] out;
        logic        zero;
        logic        carry;
        logic        ovf;
        logic        err;
    } exp_t;

    exp_t        q32[$];
    exp_t        q8[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last32 = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour computed with plain wide arithmetic
    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [31:0] a_in, input logic [31:0] b_in);
        exp_t            e;
        longint unsigned mask, a, b, bn, r;
        longint          sa, sb;
        int              sh, msb;
        msb  = w - 1;
        mask = (64'd1 << w) - 64'd1;
        a    = 64'(a_in) & mask;
        b    = 64'(b_in) & mask;
        sh   = int'(b % 64'(w));
        sa   = a[msb] ? (longint'(a) - longint'(64'd1 << w)) : longint'(a);
        sb   = b[msb] ? (longint'(b) - longint'(64'd1 << w)) : longint'(b);
        e    = '0;
        r    = 0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                r       = a + b;
                e.carry = r[w];
                r       = r & mask;
                e.ovf   = (a[msb] == b[msb]) && (r[msb] != a[msb]);
            end
            4'd3: begin
                bn      = ((~b) + 64'd1) & mask;
                e.carry = (a >= b);
                r       = (a - b) & mask;
                e.ovf   = (a[msb] == bn[msb]) && (r[msb] != a[msb]);
            end
            4'd4: r = a ^ b;
            4'd5: r = ~(a | b) & mask;
            4'd6: r = (sa < sb) ? 64'd1 : 64'd0;
            4'd7: r = (a << sh) & mask;
            4'd8: r = a >> sh;
            4'd9: r = 64'(sa >>> sh) & mask;
            4'd10: r = (a * b) & mask;
            4'd11: begin
                if (b == 0) begin r = mask; e.err = 1'b1; end
                else r = a / b;
            end
            4'd12: begin
                if (b == 0) begin r = a; e.err = 1'b1; end
                else r = a % b;
            end
            default: begin r = 0; e.err = 1'b1; end
        endcase
        e.out  = r[31:0];
        e.zero = (r == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last32 = '0;
        end else if (s32_done) begin
            check_val("q32_pending", 64'(q32.size() > 0), 64'd1);
            if (q32.size() > 0) begin
                e = q32.pop_front();
                check_val("out32",   64'(s32_out),   64'(e.out));
                check_val("zero32",  64'(s32_zero),  64'(e.zero));
                check_val("carry32", 64'(s32_carry), 64'(e.carry));
                check_val("ovf32",   64'(s32_ovf),   64'(e.ovf));
                check_val("err32",   64'(s32_err),   64'(e.err));
                check_val("busy32_at_done", 64'(s32_busy), 64'd0);
            end
            last32 = s32_out;
        end else begin
            check_val("hold32", 64'(s32_out), 64'(last32));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && s8_done) begin
            check_val("q8_pending", 64'(q8.size() > 0), 64'd1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check_val("out8",   64'(s8_out),   64'(e.out[7:0]));
                check_val("zero8",  64'(s8_zero),  64'(e.zero));
                check_val("carry8", 64'(s8_carry), 64'(e.carry));
                check_val("ovf8",   64'(s8_ovf),   64'(e.ovf));
                check_val("err8",   64'(s8_err),   64'(e.err));
            end
        end
    end

    task automatic drive(input int w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (w == 32) begin
            s32_start = 1'b1; s32_op = op; s32_a = a; s32_b = b;
            q32.push_back(model(32, op, a, b));
        end else begin
            s8_start = 1'b1; s8_op = op; s8_a = a[7:0]; s8_b = b[7:0];
            q8.push_back(model(8, op, a, b));
        end
        @(posedge clk); #1;
    endtask

    task automatic release_start();
        s32_start = 1'b0;
        s8_start  = 1'b0;
    endtask

    task automatic wait_done(input int w, input int k, input int lat, input string tag);
        for (int i = 0; i < 200; i++) begin
            if ((w == 32 && s32_done) || (w == 8 && s8_done)) begin
                check_val(tag, 64'(cyc - k), 64'(lat));
                return;
            end
            @(posedge clk); #1;
        end
        check_val({tag, "_timeout"}, 64'(w == 32 ? s32_done : s8_done), 64'd1);
    endtask

    logic [3:0]  tbl_op[9] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd14};
    logic [31:0] tbl_a[9]  = '{32'hF0F0_1234, 32'h0F00_0001, 32'hAAAA_5555, 32'h1234_0000,
                               32'hFFFF_FFFE, 32'h0000_0003, 32'h8000_0000, 32'h8000_0010,
                               32'h1234_5678};
    logic [31:0] tbl_b[9]  = '{32'hFF00_FF00, 32'h00F0_0010, 32'hFFFF_0000, 32'h0000_5678,
                               32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0021, 32'h0000_0004,
                               32'h0000_0001};

    initial begin
        int          k;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out32",   64'(s32_out),   64'd0);
        check_val("rst_zero32",  64'(s32_zero),  64'd1);
        check_val("rst_busy32",  64'(s32_busy),  64'd0);
        check_val("rst_done32",  64'(s32_done),  64'd0);
        check_val("rst_carry32", 64'(s32_carry), 64'd0);
        check_val("rst_ovf32",   64'(s32_ovf),   64'd0);
        check_val("rst_err32",   64'(s32_err),   64'd0);
        check_val("rst_zero8",   64'(s8_zero),   64'd1);
        rst_n = 1'b1;

        // ADD overflow: result visible and Done high right after the accepting edge
        drive(32, 4'd2, 32'h7FFF_FFFF, 32'h1);
        check_val("add_done", 64'(s32_done), 64'd1);
        check_val("add_out",  64'(s32_out),  64'h8000_0000);
        check_val("add_ovf",  64'(s32_ovf),  64'd1);
        check_val("add_busy", 64'(s32_busy), 64'd0);
        release_start();

        // Back-to-back single-cycle ops with Start held high
        drive(32, 4'd3, 32'd2, 32'd2);
        check_val("sub_zero", 64'(s32_zero), 64'd1);
        drive(32, 4'd3, 32'd1, 32'd2);
        check_val("sub_neg", 64'(s32_out), 64'hFFFF_FFFF);
        for (int i = 0; i < 9; i++) drive(32, tbl_op[i], tbl_a[i], tbl_b[i]);
        check_val("illegal_err", 64'(s32_err), 64'd1);
        release_start();

        // MUL with an ignored Start at k+5
        drive(32, 4'd10, 32'd6, 32'd7);
        release_start();
        k = cyc;
        check_val("mul_busy", 64'(s32_busy), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        s32_start = 1'b1; s32_op = 4'd2; s32_a = 32'd1; s32_b = 32'd1;
        @(posedge clk); #1;
        s32_start = 1'b0;
        wait_done(32, k, 32, "mul_lat");
        check_val("mul_out", 64'(s32_out), 64'd42);

        // Start accepted while in DONE
        drive(32, 4'd2, 32'd5, 32'd9);
        release_start();
        check_val("done_restart", 64'(s32_done), 64'd1);

        drive(32, 4'd11, 32'd100, 32'd7);
        release_start(); k = cyc;
        wait_done(32, k, 32, "divu_lat");
        check_val("divu_out", 64'(s32_out), 64'd14);
        drive(32, 4'd12, 32'd100, 32'd7);
        release_start(); k = cyc;
        wait_done(32, k, 32, "remu_lat");
        check_val("remu_out", 64'(s32_out), 64'd2);
        drive(32, 4'd11, 32'd123, 32'd0);
        release_start(); k = cyc;
        wait_done(32, k, 32, "divz_lat");
        check_val("divz_err", 64'(s32_err), 64'd1);
        drive(32, 4'd12, 32'hDEAD_BEEF, 32'd0);
        release_start(); k = cyc;
        wait_done(32, k, 32, "remz_lat");

        for (int i = 0; i < 16; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = (i % 4 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            drive(32, rop, ra, rb);
            release_start();
            k = cyc;
            if (rop >= 4'd10 && rop <= 4'd12) wait_done(32, k, 32, "rand_lat");
        end

        // Abort a MUL in the middle of RUN
        drive(32, 4'd10, 32'd123, 32'd456);
        release_start();
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", 64'(s32_busy), 64'd0);
        check_val("abort_done", 64'(s32_done), 64'd0);
        check_val("abort_out",  64'(s32_out),  64'd0);
        check_val("abort_zero", 64'(s32_zero), 64'd1);
        q32.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_val("abort_idle", 64'(s32_busy), 64'd0);

        // WIDTH=8 instance
        drive(8, 4'd9, 32'h80, 32'd3);
        release_start();
        check_val("sra8", 64'(s8_out), 64'hF0);
        drive(8, 4'd10, 32'd13, 32'd11);
        release_start(); k = cyc;
        wait_done(8, k, 8, "mul8_lat");
        check_val("mul8_out", 64'(s8_out), 64'h8F);
        drive(8, 4'd11, 32'd200, 32'd0);
        release_start(); k = cyc;
        wait_done(8, k, 8, "divz8_lat");
        drive(8, 4'd2, 32'h7F, 32'h1);
        release_start();
        check_val("add8_ovf", 64'(s8_ovf), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        check_val("q32_drained", 64'(q32.size()), 64'd0);
        check_val("q8_drained",  64'(q8.size()),  64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
